regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file with a configurable number of combinational read ports, one synchronous write port, write-to-read bypass, an optional hard-wired zero register (XZR) and a per-register busy scoreboard. It sits in the decode stage of the pipelined CPU. Decode reads operands from it, and the hazard unit reads the busy flags to stall on outstanding producers. Its contents and scoreboard clear asynchronously on reset.

## Interface
Parameters:
- DATA_W, 64, width of each register.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register NREG-1 is XZR: reads 0, never written, never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write register.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  mark claim_addr busy (a multi-cycle producer has issued).
- claim_addr  in  ADDR_W  register to claim.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-port "operand not yet available".
- busy_vec  out  NREG  raw scoreboard state, for debug and hazard visibility.

## Operation
- State:
  - NREG x DATA_W data flops, `regs`.
  - NREG busy flops, `busy`.
- Reset (reset_n low, asynchronous):
  - all `regs` go to 0 and all `busy` go to 0 immediately.
  - Outputs therefore read 0, rd_busy is 0 and busy_vec is 0 while reset is held.
- Write, on a rising clk edge with wr_en=1 and wr_addr not XZR:
  - `regs[wr_addr]` <= wr_data.
  - `busy[wr_addr]` <= 0, unless claimed in the same cycle (see the claim rule below).
- Claim, on a rising clk edge with claim_en=1 and claim_addr not XZR:
  - `busy[claim_addr]` <= 1.
  - Claim wins over a same-cycle write-clear to the same address, because the new producer supersedes the old one.
  - Claiming an already-busy register leaves it busy; no error is raised.
- XZR, when ZERO_REG=1:
  - writes and claims to address NREG-1 are ignored.
  - reads of NREG-1 return 0 and rd_busy is 0 for that port.
- Read port i, purely combinational. Priority order:
  1. rd_addr_i == XZR (ZERO_REG=1) -> 0.
  2. wr_en && wr_addr == rd_addr_i -> wr_data (bypass).
  3. otherwise -> `regs[rd_addr_i]`.
- rd_busy[i] = `busy[rd_addr_i]` AND NOT (wr_en && wr_addr == rd_addr_i) AND NOT XZR. A same-cycle write satisfies the operand.
- A same-cycle claim does not affect rd_busy or rd_data in that cycle.
- Any number of read ports may read the same address; all of them see the same value.
- A write with wr_en=0 changes nothing, whatever the values on wr_addr and wr_data.

## Timing
- Write latency: data is in `regs` after the edge. Through the bypass it is visible on rd_data in the same cycle it is presented.
- Claim latency: busy_vec and rd_busy reflect a claim from the cycle after the claim edge.
- Clearing busy follows the write rule: rd_busy drops in the write cycle via the bypass term, and busy_vec drops after the edge.
- Reset asserted mid-operation: state clears asynchronously, and any write or claim on that edge is lost.
- Reset deassertion: the first edge with reset_n=1 performs normal writes and claims.
- Combinational path: rd_addr/wr_* -> rd_data/rd_busy has no flop; downstream logic must register it.

## Test plan
- Reset: preload R3=0xAA, set busy[3], then pulse reset_n low between clock edges -> rd_data=0 and busy_vec=0 immediately, before the next edge.
- Write/read/bypass: write R5=0x1234_5678_9ABC_DEF0 while rd_addr0=5 -> rd_data0=0x1234_5678_9ABC_DEF0 in the same cycle. After the edge with wr_en=0 -> value unchanged on both ports.
- XZR: write 0xFFFF to R31 and claim R31 -> rd_data for R31 =0, rd_busy=0, busy_vec[31]=0. With ZERO_REG=0 -> R31 reads 0xFFFF.
- Scoreboard: claim R7 -> next cycle rd_busy0=1 and busy_vec[7]=1. Write R7=0x42 -> rd_busy0=0 and rd_data0=0x42 that cycle; busy_vec[7]=0 after the edge.
- Claim/write collision: claim R9 and write R9=0x9 on the same edge -> busy[9]=1 and `regs[9]`=0x9 afterwards.
- Parametrisation: DATA_W=32, ADDR_W=4, NUM_RD=3, all three ports reading R2=0xDEAD simultaneously -> all three ports return 0xDEAD. Random writes checked against a reference model over 10k cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Decode-stage register file: N combinational read ports, one write port with
// same-cycle bypass, optional hard-wired zero register and a busy scoreboard.
module regfile_param #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       claim_en,
   input  logic [ADDR_W-1:0]          claim_addr,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};
   localparam logic HAS_ZERO = (ZERO_REG != 0);

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_busy;

   logic w_wr_ok;
   logic w_claim_ok;
   logic w_wr_live;

   assign w_wr_ok    = wr_en && !(HAS_ZERO && (wr_addr == XZR));
   assign w_claim_ok = claim_en && !(HAS_ZERO && (claim_addr == XZR));
   // A write presented while reset is held is lost, so it must not bypass either.
   assign w_wr_live  = wr_en && reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
            r_busy[wr_addr] <= 1'b0;
         end
         // Placed after the write so a same-edge claim supersedes the clear.
         if (w_claim_ok) begin
            r_busy[claim_addr] <= 1'b1;
         end
      end
   end

   assign busy_vec = r_busy;

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_is_zero;
      logic              w_hit;

      assign w_ra      = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_is_zero = HAS_ZERO && (w_ra == XZR);
      assign w_hit     = w_wr_live && (wr_addr == w_ra);

      assign rd_data[gi*DATA_W +: DATA_W] = w_is_zero ? '0 :
                                            w_hit     ? wr_data :
                                                        r_regs[w_ra];
      assign rd_busy[gi] = r_busy[w_ra] && !w_hit && !w_is_zero;
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed and model-checked bench for regfile_param: default build, a build
// without the zero register, and a narrow three-port build.
module tb_regfile_param;

   logic         clk;
   logic         reset_n;

   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [63:0]  wr_data;
   logic         claim_en;
   logic [4:0]   claim_addr;
   logic [9:0]   rd_addr;
   logic [127:0] rd_data;
   logic [1:0]   rd_busy;
   logic [31:0]  busy_vec;

   logic [127:0] nz_rd_data;
   logic [1:0]   nz_rd_busy;
   logic [31:0]  nz_busy_vec;

   logic         p_wr_en;
   logic [3:0]   p_wr_addr;
   logic [31:0]  p_wr_data;
   logic         p_claim_en;
   logic [3:0]   p_claim_addr;
   logic [11:0]  p_rd_addr;
   logic [95:0]  p_rd_data;
   logic [2:0]   p_rd_busy;
   logic [15:0]  p_busy_vec;

   int checks;
   int errors;

   logic [63:0] m_regs [32];
   logic [31:0] m_busy;

   regfile_param u_dut (
      .clk(clk), .reset_n(reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .busy_vec(busy_vec)
   );

   regfile_param #(.ZERO_REG(0)) u_nz (
      .clk(clk), .reset_n(reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(nz_rd_data), .rd_busy(nz_rd_busy), .busy_vec(nz_busy_vec)
   );

   regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) u_p (
      .clk(clk), .reset_n(reset_n),
      .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
      .claim_en(p_claim_en), .claim_addr(p_claim_addr),
      .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy), .busy_vec(p_busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; claim_en = 1'b0;
      p_wr_en = 1'b0; p_claim_en = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_d;
      logic        exp_b;
      logic [4:0]  a;

      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      claim_en = 1'b0; claim_addr = '0; rd_addr = '0;
      p_wr_en = 1'b0; p_wr_addr = '0; p_wr_data = '0;
      p_claim_en = 1'b0; p_claim_addr = '0; p_rd_addr = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd0", rd_data[63:0], 64'h0);
      chk("rst_busy", {32'h0, busy_vec}, 64'h0);
      reset_n = 1'b1;
      step();

      // Preload R3 and mark it busy, then pulse reset between edges.
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hAA;
      claim_en = 1'b1; claim_addr = 5'd3;
      step();
      idle();
      rd_addr = {5'd0, 5'd3};
      #1;
      chk("pre_rst_r3", rd_data[63:0], 64'hAA);
      chk("pre_rst_busy3", {63'h0, busy_vec[3]}, 64'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_r3", rd_data[63:0], 64'h0);
      chk("async_rst_busy", {32'h0, busy_vec}, 64'h0);
      chk("async_rst_rdbusy", {62'h0, rd_busy}, 64'h0);
      #2 reset_n = 1'b1;
      step();

      // Write with same-cycle bypass on both ports.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234_5678_9ABC_DEF0;
      rd_addr = {5'd5, 5'd5};
      #1;
      chk("byp_p0", rd_data[63:0], 64'h1234_5678_9ABC_DEF0);
      chk("byp_p1", rd_data[127:64], 64'h1234_5678_9ABC_DEF0);
      step();
      wr_en = 1'b0; wr_data = 64'hDEAD_BEEF_0000_1111;
      #1;
      chk("hold_p0", rd_data[63:0], 64'h1234_5678_9ABC_DEF0);
      chk("hold_p1", rd_data[127:64], 64'h1234_5678_9ABC_DEF0);
      step();
      chk("noen_p0", rd_data[63:0], 64'h1234_5678_9ABC_DEF0);

      // Zero register: ignored in default build, ordinary in ZERO_REG=0 build.
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF;
      claim_en = 1'b1; claim_addr = 5'd31;
      rd_addr = {5'd0, 5'd31};
      #1;
      chk("xzr_byp", rd_data[63:0], 64'h0);
      chk("nz_byp", nz_rd_data[63:0], 64'hFFFF);
      step();
      idle();
      #1;
      chk("xzr_rd", rd_data[63:0], 64'h0);
      chk("xzr_rdbusy", {63'h0, rd_busy[0]}, 64'h0);
      chk("xzr_busyvec", {63'h0, busy_vec[31]}, 64'h0);
      chk("nz_rd", nz_rd_data[63:0], 64'hFFFF);
      chk("nz_busyvec", {63'h0, nz_busy_vec[31]}, 64'h1);

      // Scoreboard: claim visible next cycle, write clears via bypass then flop.
      claim_en = 1'b1; claim_addr = 5'd7;
      rd_addr = {5'd0, 5'd7};
      #1;
      chk("claim_same_cyc", {63'h0, rd_busy[0]}, 64'h0);
      step();
      idle();
      #1;
      chk("claim_rdbusy", {63'h0, rd_busy[0]}, 64'h1);
      chk("claim_busyvec", {63'h0, busy_vec[7]}, 64'h1);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h42;
      #1;
      chk("clr_rdbusy", {63'h0, rd_busy[0]}, 64'h0);
      chk("clr_rd", rd_data[63:0], 64'h42);
      chk("clr_busyvec_pre", {63'h0, busy_vec[7]}, 64'h1);
      step();
      idle();
      #1;
      chk("clr_busyvec", {63'h0, busy_vec[7]}, 64'h0);
      chk("clr_rd_post", rd_data[63:0], 64'h42);

      // Claim and write to the same register on one edge: claim wins.
      claim_en = 1'b1; claim_addr = 5'd9;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h9;
      step();
      idle();
      rd_addr = {5'd0, 5'd9};
      #1;
      chk("coll_busyvec", {63'h0, busy_vec[9]}, 64'h1);
      chk("coll_rdbusy", {63'h0, rd_busy[0]}, 64'h1);
      chk("coll_rd", rd_data[63:0], 64'h9);

      // Narrow three-port build: every port reads R2.
      p_wr_en = 1'b1; p_wr_addr = 4'd2; p_wr_data = 32'hDEAD;
      step();
      idle();
      p_rd_addr = {4'd2, 4'd2, 4'd2};
      #1;
      chk("p3_port0", {32'h0, p_rd_data[31:0]}, 64'hDEAD);
      chk("p3_port1", {32'h0, p_rd_data[63:32]}, 64'hDEAD);
      chk("p3_port2", {32'h0, p_rd_data[95:64]}, 64'hDEAD);
      p_rd_addr = {4'd15, 4'd2, 4'd0};
      #1;
      chk("p3_xzr", {32'h0, p_rd_data[95:64]}, 64'h0);

      // Random traffic against a reference model, starting from reset.
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
      step();
      for (int c = 0; c < 10000; c++) begin
         wr_en      = ($urandom_range(0, 1) == 1);
         wr_addr    = 5'($urandom_range(0, 31));
         wr_data    = {$urandom, $urandom};
         claim_en   = ($urandom_range(0, 3) == 0);
         claim_addr = 5'($urandom_range(0, 31));
         rd_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
         #1;
         for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            if (a == 5'd31) begin
               exp_d = '0; exp_b = 1'b0;
            end else if (wr_en && wr_addr == a) begin
               exp_d = wr_data; exp_b = 1'b0;
            end else begin
               exp_d = m_regs[a]; exp_b = m_busy[a];
            end
            chk("rnd_rd", rd_data[p*64 +: 64], exp_d);
            chk("rnd_rdbusy", {63'h0, rd_busy[p]}, {63'h0, exp_b});
         end
         chk("rnd_busyvec", {32'h0, busy_vec}, {32'h0, m_busy});
         if (wr_en && wr_addr != 5'd31) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
         end
         if (claim_en && claim_addr != 5'd31) m_busy[claim_addr] = 1'b1;
         step();
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
